// File: rtl/i2s_audio_receiver.sv
// Oversampled I2S receiver: synchronises BCLK/LRCLK/SDATA into clk, deserialises
// MSB-first slots and emits channel-tagged PCM words over a valid/ready port.
module i2s_audio_receiver #(
  parameter int   data_width  = 16,
  parameter int   sync_stages = 2,
  parameter logic left_level  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_is_left,
  output logic [data_width-1:0] o_audio,
  output logic                  o_overrun,
  output logic                  o_frame_error
);

  localparam int cnt_w = $clog2(data_width + 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(data_width);

  typedef enum logic {SYNC, RECV} state_t;

  state_t                  state, state_next;
  logic [sync_stages-1:0]  bclk_sync, lrclk_sync, data_sync;
  logic                    bclk_prev;
  logic                    bclk_s, lr_s, data_s, strobe;
  logic [cnt_w-1:0]        bit_cnt, cnt_next;
  logic [data_width-1:0]   shift_reg, shift_next;
  logic                    channel, channel_next;
  logic                    lr_prev, lr_prev_next;
  logic                    lr_seen, lr_seen_next;
  logic                    done_next, err_next;
  logic                    word_done, word_left;
  logic [data_width-1:0]   word_reg;

  assign bclk_s = bclk_sync[sync_stages-1];
  assign lr_s   = lrclk_sync[sync_stages-1];
  assign data_s = data_sync[sync_stages-1];
  assign strobe = bclk_s & ~bclk_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      data_sync  <= '0;
      bclk_prev  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[sync_stages-2:0], i2s_bclk};
      lrclk_sync <= {lrclk_sync[sync_stages-2:0], i2s_lrclk};
      data_sync  <= {data_sync[sync_stages-2:0], i2s_data};
      bclk_prev  <= bclk_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_next;
  end

  // Shift happens before transition handling so the delayed bit lands in the old slot;
  // the first strobe after reset only records LRCLK so a mid-slot start is never a transition.
  always_comb begin
    state_next   = state;
    cnt_next     = bit_cnt;
    shift_next   = shift_reg;
    channel_next = channel;
    lr_prev_next = lr_prev;
    lr_seen_next = lr_seen;
    done_next    = 1'b0;
    err_next     = 1'b0;
    if (strobe) begin
      if (state == RECV && bit_cnt < cnt_full) begin
        shift_next = {shift_reg[data_width-2:0], data_s};
        cnt_next   = bit_cnt + cnt_w'(1);
        done_next  = (cnt_next == cnt_full);
      end
      lr_prev_next = lr_s;
      lr_seen_next = 1'b1;
      if (lr_seen && lr_s != lr_prev) begin
        if (state == RECV && cnt_next != '0 && cnt_next < cnt_full)
          err_next = 1'b1;
        channel_next = (lr_s == left_level);
        cnt_next     = '0;
        state_next   = RECV;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt       <= '0;
      shift_reg     <= '0;
      channel       <= 1'b0;
      lr_prev       <= 1'b0;
      lr_seen       <= 1'b0;
      word_done     <= 1'b0;
      word_left     <= 1'b0;
      word_reg      <= '0;
      o_frame_error <= 1'b0;
    end else begin
      bit_cnt       <= cnt_next;
      shift_reg     <= shift_next;
      channel       <= channel_next;
      lr_prev       <= lr_prev_next;
      lr_seen       <= lr_seen_next;
      word_done     <= done_next;
      o_frame_error <= err_next;
      if (done_next) begin
        word_reg  <= shift_next;
        word_left <= channel;
      end
    end
  end

  // A completed word loads only when the output slot is free or being accepted this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid   <= 1'b0;
      o_is_left <= 1'b0;
      o_audio   <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (word_done) begin
        if (!o_valid || o_ready) begin
          o_valid   <= 1'b1;
          o_audio   <= word_reg;
          o_is_left <= word_left;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
